// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg
// Description : Shared constants and state encoding for the SD block
//               Wishbone transfer stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

  localparam int SD_WORDS_PER_BLOCK = 128;
  localparam int SD_WORD_BITS       = 7;   // log2(SD_WORDS_PER_BLOCK)
  localparam int SD_BLOCK_SHIFT     = 9;   // 512-byte blocks

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_REQ   = 3'd1,
    ST_RD_DONE  = 3'd2,
    ST_WR_FETCH = 3'd3,
    ST_WR_REQ   = 3'd4,
    ST_WR_DONE  = 3'd5
  } sd_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_sync_n.sv
`default_nettype none
// ============================================================================
// Module      : sd_sync_n
// Description : Flop-chain synchroniser for a single level signal.
//   clk   : destination clock
//   rst   : asynchronous active-high reset, clears the chain
//   i_d   : asynchronous input level
//   o_q   : synchronised level, STAGES cycles later
// Revision    : 1.0 - initial release
// ============================================================================
module sd_sync_n #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_chain <= '0;
        else     r_chain <= i_d;
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_chain <= '0;
        else     r_chain <= {r_chain[STAGES-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sd_wb_xfer.sv
`default_nettype none
// ============================================================================
// Module      : sd_wb_xfer
// Description : Wishbone master moving 128-word SD blocks between Wishbone
//               space and the read/write buffer BRAMs of the sector manager.
//   clk_50, reset          : Wishbone/BRAM clock, async active-high reset
//   ext_read_*             : block-read handshake (act/addr in, go out, stop in)
//   ext_write_*            : block-write handshake (act/addr in, done out)
//   bram_rd_ext_*          : read-buffer fill port (addr/wren/data)
//   bram_wr_ext_addr/_q    : write-buffer drain port, q has 1-cycle latency
//   wb_*                   : Wishbone classic master
//   xfer_err               : sticky bus-error flag, cleared only by reset
// Revision    : 1.0 - initial release
// ============================================================================
module sd_wb_xfer
  import sd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          SYNC_STAGES = 3
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        ext_read_act,
  input  logic [31:0] ext_read_addr,
  input  logic        ext_read_stop,
  output logic        ext_read_go,
  input  logic        ext_write_act,
  input  logic [31:0] ext_write_addr,
  output logic        ext_write_done,
  output logic [6:0]  bram_rd_ext_addr,
  output logic        bram_rd_ext_wren,
  output logic [31:0] bram_rd_ext_data,
  output logic [6:0]  bram_wr_ext_addr,
  input  logic [31:0] bram_wr_ext_q,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        xfer_err
);

  logic w_rd_act;
  logic w_rd_stop;
  logic w_wr_act;

  sd_sync_n #(.STAGES(SYNC_STAGES)) u_sync_rd_act (
    .clk (clk_50), .rst (reset), .i_d (ext_read_act),  .o_q (w_rd_act)
  );
  sd_sync_n #(.STAGES(SYNC_STAGES)) u_sync_rd_stop (
    .clk (clk_50), .rst (reset), .i_d (ext_read_stop), .o_q (w_rd_stop)
  );
  sd_sync_n #(.STAGES(SYNC_STAGES)) u_sync_wr_act (
    .clk (clk_50), .rst (reset), .i_d (ext_write_act), .o_q (w_wr_act)
  );

  sd_state_t                 r_state;
  logic [31:0]               r_blk;
  logic [SD_WORD_BITS-1:0]   r_word;
  logic                      r_cyc;
  logic                      r_stb;
  logic                      r_we;
  logic                      r_go;
  logic                      r_done;
  logic                      r_err;
  logic                      r_wren;
  logic [SD_WORD_BITS-1:0]   r_rd_addr;
  logic [31:0]               r_rd_data;
  logic [31:0]               r_dat_o;

  logic [31:0] w_adr;
  logic        w_last;
  logic        w_beat_end;

  // Byte address of the current word; 32-bit arithmetic wraps naturally.
  assign w_adr      = BASE_ADDR + (r_blk << SD_BLOCK_SHIFT)
                    + {{(30-SD_WORD_BITS){1'b0}}, r_word, 2'b00};
  assign w_last     = (r_word == SD_WORD_BITS'(SD_WORDS_PER_BLOCK - 1));
  // A beat terminates on ack or err, but only while strobe is really out.
  assign w_beat_end = r_stb & (wb_ack_i | wb_err_i);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_blk     <= '0;
      r_word    <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_go      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wren    <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_dat_o   <= '0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rd_act) begin
            r_blk   <= ext_read_addr;
            r_word  <= '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_state <= ST_RD_REQ;
          end else if (w_wr_act && !r_done) begin
            r_blk   <= ext_write_addr;
            r_word  <= '0;
            r_state <= ST_WR_FETCH;
          end
        end

        ST_RD_REQ: begin
          if (w_beat_end) begin
            // Strobe idles one cycle while the word lands in the buffer.
            r_stb     <= 1'b0;
            r_wren    <= 1'b1;
            r_rd_addr <= r_word;
            r_rd_data <= wb_err_i ? 32'd0 : wb_dat_i;
            if (wb_err_i) r_err <= 1'b1;
            if (w_last) begin
              r_cyc   <= 1'b0;
              r_go    <= 1'b1;
              r_state <= ST_RD_DONE;
            end else begin
              r_word  <= r_word + 1'b1;
            end
          end else begin
            r_stb <= 1'b1;
          end
        end

        ST_RD_DONE: begin
          // go drops on stop; leave only once both stop and act are low.
          if (r_go) begin
            if (w_rd_stop) r_go <= 1'b0;
          end else if (!w_rd_stop && !w_rd_act) begin
            r_state <= ST_IDLE;
          end
        end

        ST_WR_FETCH: begin
          // bram_wr_ext_addr follows r_word; q is valid next cycle.
          r_state <= ST_WR_REQ;
        end

        ST_WR_REQ: begin
          if (!r_stb) begin
            r_dat_o <= bram_wr_ext_q;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
          end else if (w_beat_end) begin
            r_stb <= 1'b0;
            if (wb_err_i) r_err <= 1'b1;
            if (w_last) begin
              r_cyc   <= 1'b0;
              r_we    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_WR_DONE;
            end else begin
              r_word  <= r_word + 1'b1;
              r_state <= ST_WR_FETCH;
            end
          end
        end

        ST_WR_DONE: begin
          if (!w_wr_act) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ext_read_go      = r_go;
  assign ext_write_done   = r_done;
  assign xfer_err         = r_err;
  assign bram_rd_ext_addr = r_rd_addr;
  assign bram_rd_ext_wren = r_wren;
  assign bram_rd_ext_data = r_rd_data;
  assign bram_wr_ext_addr = r_word;
  assign wb_adr_o         = r_cyc ? w_adr : 32'd0;
  assign wb_sel_o         = r_cyc ? 4'hF : 4'h0;
  assign wb_dat_o         = r_dat_o;
  assign wb_we_o          = r_we;
  assign wb_cyc_o         = r_cyc;
  assign wb_stb_o         = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_sd_wb_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_wb_xfer
// Description : Directed self-checking bench for sd_wb_xfer. A second
//               instance with a high BASE_ADDR exercises address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_wb_xfer;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        ext_read_act, ext_read_stop, ext_write_act;
  logic [31:0] ext_read_addr, ext_write_addr;
  logic        ext_read_go, ext_write_done;
  logic [6:0]  bram_rd_ext_addr, bram_wr_ext_addr;
  logic        bram_rd_ext_wren;
  logic [31:0] bram_rd_ext_data;
  logic [31:0] bram_wr_ext_q;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic [3:0]  wb_sel_o;
  logic        xfer_err;

  // wrap instance
  logic        w2_read_act;
  logic [31:0] w2_read_addr;
  logic        w2_go, w2_done, w2_wren, w2_we, w2_cyc, w2_stb, w2_err;
  logic [6:0]  w2_rd_addr, w2_wr_addr;
  logic [31:0] w2_rd_data, w2_adr, w2_dat_o;
  logic [3:0]  w2_sel;

  logic        err_en;
  logic [31:0] err_adr;
  logic        err_hit;

  always #5 clk_50 = ~clk_50;

  sd_wb_xfer #(.BASE_ADDR(32'h0000_0000), .SYNC_STAGES(3)) u_dut (
    .clk_50(clk_50), .reset(reset),
    .ext_read_act(ext_read_act), .ext_read_addr(ext_read_addr),
    .ext_read_stop(ext_read_stop), .ext_read_go(ext_read_go),
    .ext_write_act(ext_write_act), .ext_write_addr(ext_write_addr),
    .ext_write_done(ext_write_done),
    .bram_rd_ext_addr(bram_rd_ext_addr), .bram_rd_ext_wren(bram_rd_ext_wren),
    .bram_rd_ext_data(bram_rd_ext_data),
    .bram_wr_ext_addr(bram_wr_ext_addr), .bram_wr_ext_q(bram_wr_ext_q),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .xfer_err(xfer_err)
  );

  sd_wb_xfer #(.BASE_ADDR(32'hFFFF_FE00), .SYNC_STAGES(3)) u_wrap (
    .clk_50(clk_50), .reset(reset),
    .ext_read_act(w2_read_act), .ext_read_addr(w2_read_addr),
    .ext_read_stop(1'b0), .ext_read_go(w2_go),
    .ext_write_act(1'b0), .ext_write_addr(32'd0),
    .ext_write_done(w2_done),
    .bram_rd_ext_addr(w2_rd_addr), .bram_rd_ext_wren(w2_wren),
    .bram_rd_ext_data(w2_rd_data),
    .bram_wr_ext_addr(w2_wr_addr), .bram_wr_ext_q(32'd0),
    .wb_adr_o(w2_adr), .wb_dat_o(w2_dat_o), .wb_dat_i(w2_adr),
    .wb_we_o(w2_we), .wb_sel_o(w2_sel), .wb_cyc_o(w2_cyc),
    .wb_stb_o(w2_stb), .wb_ack_i(w2_cyc & w2_stb), .wb_err_i(1'b0),
    .xfer_err(w2_err)
  );

  // Wishbone slave: zero-wait ack, read data equals address, optional error.
  assign err_hit  = err_en && (wb_adr_o == err_adr);
  assign wb_ack_i = wb_cyc_o & wb_stb_o & ~err_hit;
  assign wb_err_i = wb_cyc_o & wb_stb_o & err_hit;
  assign wb_dat_i = wb_adr_o;

  // Write-buffer BRAM model preloaded with i*3.
  logic [31:0] wr_mem [0:127];
  initial for (int i = 0; i < 128; i++) wr_mem[i] = 32'(i * 3);
  always @(posedge clk_50) bram_wr_ext_q <= wr_mem[bram_wr_ext_addr];

  // Read-buffer capture and bus-beat log.
  logic [31:0] rd_mem   [0:127];
  logic [31:0] beat_adr [0:2047];
  logic [31:0] beat_dat [0:2047];
  logic        beat_we  [0:2047];
  int beat_cnt = 0;
  int wren_cnt = 0;

  always @(negedge clk_50) begin
    if (bram_rd_ext_wren) begin
      rd_mem[bram_rd_ext_addr] <= bram_rd_ext_data;
      wren_cnt <= wren_cnt + 1;
    end
    if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
      if (beat_cnt < 2048) begin
        beat_adr[beat_cnt] <= wb_adr_o;
        beat_dat[beat_cnt] <= wb_dat_o;
        beat_we[beat_cnt]  <= wb_we_o;
      end
      beat_cnt <= beat_cnt + 1;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  // Checks 128 logged beats starting at b0 against a block base address.
  task automatic check_beats(input string tag, input int b0,
                             input logic [31:0] a0, input logic we,
                             input bit wr);
    int ea = 0, ew = 0, ed = 0;
    for (int i = 0; i < 128; i++) begin
      if (beat_adr[b0+i] !== a0 + 32'(i * 4)) ea++;
      if (beat_we[b0+i] !== we) ew++;
      if (wr && (beat_dat[b0+i] !== 32'(i * 3))) ed++;
    end
    check_value({tag, "_adr_first"}, beat_adr[b0], a0);
    check_value({tag, "_adr_last"}, beat_adr[b0+127], a0 + 32'h1FC);
    check_value({tag, "_adr_errs"}, ea, 0);
    check_value({tag, "_we_errs"}, ew, 0);
    if (wr) check_value({tag, "_dat_errs"}, ed, 0);
  endtask

  task automatic read_handshake(input string tag);
    ext_read_stop = 1'b1;
    for (int i = 0; i < 20 && ext_read_go; i++) tick(1);
    check_value({tag, "_go_fall"}, ext_read_go, 0);
    ext_read_stop = 1'b0;
    ext_read_act  = 1'b0;
    tick(8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b0, w0, errs;
    reset = 1'b1;
    ext_read_act = 0; ext_read_stop = 0; ext_write_act = 0;
    ext_read_addr = 0; ext_write_addr = 0;
    w2_read_act = 0; w2_read_addr = 0;
    err_en = 0; err_adr = 0;
    tick(3);
    check_value("rst_cyc", wb_cyc_o, 0);
    check_value("rst_stb", wb_stb_o, 0);
    check_value("rst_go", ext_read_go, 0);
    check_value("rst_done", ext_write_done, 0);
    check_value("rst_wren", bram_rd_ext_wren, 0);
    check_value("rst_err", xfer_err, 0);
    check_value("rst_adr", wb_adr_o, 0);
    check_value("rst_sel", wb_sel_o, 0);
    reset = 1'b0;
    tick(2);

    // Read block 5
    b0 = beat_cnt; w0 = wren_cnt;
    ext_read_addr = 32'd5; ext_read_act = 1'b1;
    for (int i = 0; i < 2000 && !ext_read_go; i++) tick(1);
    check_value("rd5_go", ext_read_go, 1);
    check_value("rd5_beats_at_go", beat_cnt - b0, 128);
    tick(2);
    check_beats("rd5", b0, 32'h0000_0A00, 1'b0, 1'b0);
    check_value("rd5_wren_cnt", wren_cnt - w0, 128);
    errs = 0;
    for (int i = 0; i < 128; i++)
      if (rd_mem[i] !== 32'h0A00 + 32'(i * 4)) errs++;
    check_value("rd5_data_errs", errs, 0);
    check_value("rd5_go_held", ext_read_go, 1);
    read_handshake("rd5");

    // Write block 2
    b0 = beat_cnt;
    ext_write_addr = 32'd2; ext_write_act = 1'b1;
    for (int i = 0; i < 3000 && !ext_write_done; i++) tick(1);
    check_value("wr2_done", ext_write_done, 1);
    check_value("wr2_beats", beat_cnt - b0, 128);
    check_beats("wr2", b0, 32'h0000_0400, 1'b1, 1'b1);
    tick(10);
    check_value("wr2_done_held", ext_write_done, 1);
    ext_write_act = 1'b0;
    for (int i = 0; i < 20 && ext_write_done; i++) tick(1);
    check_value("wr2_done_fall", ext_write_done, 0);
    tick(8);

    // Simultaneous read (blk 7) and write (blk 3)
    b0 = beat_cnt;
    ext_read_addr = 32'd7; ext_write_addr = 32'd3;
    ext_read_act = 1'b1; ext_write_act = 1'b1;
    for (int i = 0; i < 2000 && !ext_read_go; i++) tick(1);
    check_value("sim_rd_go", ext_read_go, 1);
    check_value("sim_rd_beats", beat_cnt - b0, 128);
    check_beats("sim_rd", b0, 32'h0000_0E00, 1'b0, 1'b0);
    tick(10);
    check_value("sim_wr_waits", beat_cnt - b0, 128);
    read_handshake("sim_rd");
    for (int i = 0; i < 3000 && !ext_write_done; i++) tick(1);
    check_value("sim_wr_done", ext_write_done, 1);
    check_value("sim_total_beats", beat_cnt - b0, 256);
    check_beats("sim_wr", b0 + 128, 32'h0000_0600, 1'b1, 1'b1);
    ext_write_act = 1'b0;
    for (int i = 0; i < 20 && ext_write_done; i++) tick(1);
    tick(8);

    // Bus error on beat 10 of a read of block 4
    b0 = beat_cnt;
    err_adr = 32'h0000_0800 + 32'd40; err_en = 1'b1;
    ext_read_addr = 32'd4; ext_read_act = 1'b1;
    for (int i = 0; i < 2000 && !ext_read_go; i++) tick(1);
    check_value("err_go", ext_read_go, 1);
    tick(2);
    check_value("err_beats", beat_cnt - b0, 128);
    check_value("err_word10", rd_mem[10], 32'd0);
    check_value("err_word11", rd_mem[11], 32'h0000_082C);
    check_value("err_word9", rd_mem[9], 32'h0000_0824);
    check_value("err_flag", xfer_err, 1);
    read_handshake("err");
    err_en = 1'b0;
    check_value("err_sticky", xfer_err, 1);

    // Address wrap on the high-base instance
    w2_read_addr = 32'd1; w2_read_act = 1'b1;
    for (int i = 0; i < 20 && !w2_cyc; i++) tick(1);
    check_value("wrap_cyc", w2_cyc, 1);
    check_value("wrap_adr0", w2_adr, 32'h0000_0000);
    check_value("wrap_sel", w2_sel, 4'hF);
    for (int i = 0; i < 10 && w2_stb; i++) tick(1);
    for (int i = 0; i < 10 && !w2_stb; i++) tick(1);
    check_value("wrap_adr1", w2_adr, 32'h0000_0004);
    w2_read_act = 1'b0;

    // Reset in the middle of a write, then restart
    b0 = beat_cnt;
    ext_write_addr = 32'd2; ext_write_act = 1'b1;
    for (int i = 0; i < 2000 && (beat_cnt - b0) < 60; i++) tick(1);
    check_value("rst_mid_beats", beat_cnt - b0, 60);
    #2;
    reset = 1'b1;
    #1;
    check_value("rst_mid_cyc", wb_cyc_o, 0);
    check_value("rst_mid_stb", wb_stb_o, 0);
    check_value("rst_mid_done", ext_write_done, 0);
    check_value("rst_mid_err", xfer_err, 0);
    tick(2);
    reset = 1'b0;
    b0 = beat_cnt;
    for (int i = 0; i < 3000 && !ext_write_done; i++) tick(1);
    check_value("rst_re_done", ext_write_done, 1);
    check_value("rst_re_beats", beat_cnt - b0, 128);
    check_beats("rst_re", b0, 32'h0000_0400, 1'b1, 1'b1);
    ext_write_act = 1'b0;
    for (int i = 0; i < 20 && ext_write_done; i++) tick(1);
    check_value("rst_re_done_fall", ext_write_done, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_wb_xfer.md
Name: sd_wb_xfer

Overview:
- Wishbone master stage directly downstream of the SD sector manager's external port.
- Services block-read requests (ext_read_act / ext_read_go / ext_read_stop): fetches 128 words from Wishbone into the read buffer BRAM.
- Services block-write requests (ext_write_act / ext_write_done): drains 128 words from the write buffer BRAM to Wishbone.
- Runs entirely on the Wishbone-side clock, which also clocks the BRAM external ports.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of SD block 0 in Wishbone space.
- SYNC_STAGES, 3, flop depth of the input synchronisers on ext_read_act, ext_read_stop and ext_write_act.

Ports:
- clk_50 in 1: Wishbone/BRAM-side clock.
- reset in 1: asynchronous, active-high reset.
- ext_read_act in 1: read request from the manager, level.
- ext_read_addr in 32: block number, stable while act is high.
- ext_read_stop in 1: manager acknowledgement of go.
- ext_read_go out 1: buffer filled.
- ext_write_act in 1: write request, level.
- ext_write_addr in 32: block number.
- ext_write_done out 1: buffer flushed.
- bram_rd_ext_addr out 7, bram_rd_ext_wren out 1, bram_rd_ext_data out 32: read-buffer fill port.
- bram_wr_ext_addr out 7: write-buffer drain address.
- bram_wr_ext_q in 32: drain data, one-cycle read latency.
- wb_adr_o out 32, wb_dat_o out 32, wb_dat_i in 32, wb_we_o out 1, wb_sel_o out 4, wb_cyc_o out 1, wb_stb_o out 1, wb_ack_i in 1, wb_err_i in 1.
- xfer_err out 1: sticky, set if any wb_err_i is seen during a transfer.

Behaviour:
- Reset (async, immediate): all outputs 0, including go, done, cyc, stb, wren and xfer_err; state IDLE; word counter 0. A reset mid-cycle drops cyc/stb at once, with no Wishbone completion.
- act and stop are used only after SYNC_STAGES flops; block addresses are captured on the synced act rising edge (act masks addr stability).
- Addressing: wb_adr_o = BASE_ADDR + (blk << 9) + (word << 2), computed mod 2^32 with wrap permitted. wb_sel_o = 4'hF. The word counter is 7 bits, 0..127.
- States: IDLE, RD_REQ, RD_DONE, WR_FETCH, WR_REQ, WR_DONE.
- IDLE:
  - synced read act high -> latch blk, word=0, go to RD_REQ.
  - else synced write act high and done==0 -> latch blk, word=0, go to WR_FETCH.
  - Read has priority on simultaneous requests.
- RD_REQ:
  - cyc=stb=1, we=0.
  - On ack or err: bram_rd_ext_wren pulses for 1 cycle with addr=word and data=wb_dat_i (0 on err, and xfer_err set); stb drops for one cycle between beats.
  - word==127 -> cyc=0, go to RD_DONE; else word+1.
- RD_DONE:
  - ext_read_go=1, held until synced stop==1.
  - Then go=0 and remain in RD_DONE until synced stop==0 and synced act==0, then IDLE.
  - Minimum 128 beats x 2 cycles + sync latency per block.
- WR_FETCH:
  - Drive bram_wr_ext_addr=word; wait 1 cycle for q; go to WR_REQ.
- WR_REQ:
  - cyc=stb=1, we=1, wb_dat_o = registered bram_wr_ext_q.
  - On ack/err (err sets xfer_err): word==127 -> cyc=0, go to WR_DONE; else word+1, go to WR_FETCH.
- WR_DONE:
  - ext_write_done=1, held until synced write act==0, then done=0, IDLE.
  - IDLE must not restart a write while done is still high.
- A request whose act deasserts mid-transfer is still completed in full; the handshake then finishes normally.
- xfer_err clears only on reset.

Decomposition:
- Shared package sd_pkg:
  - state encoding constants.
  - SD_WORDS_PER_BLOCK = 128.
  - SD_BLOCK_SHIFT = 9.
- Sub-module: sd_sync_n (parameterised flop-chain synchroniser), instantiated three times.

Test Plan:
- Read blk 5, BASE 0, slave data = address: wb_adr_o steps 0xA00..0xBFC; 128 wren pulses with data==address; go rises after the last beat, and falls once stop is asserted.
- Write blk 2, BRAM preloaded with i*3: 128 writes to 0x400..0x5FC with dat_o==i*3; done=1 until act drops, then 0.
- Read and write act asserted in the same cycle: read is serviced first, then the write, with no overlap of cyc.
- wb_err_i on beat 10 of a read: BRAM word 10 = 0, xfer_err=1 and stays high; transfer completes 128 beats.
- Address wrap, BASE=32'hFFFF_FE00 and blk 1: first adr 0x0000_0000.
- Reset asserted at beat 60 of a write: cyc/stb/done drop at once; the next request restarts at word 0.
